// File: rtl/fma_fp16_int8_pkg.sv
// fma_fp16_int8_pkg: FP16 format constants, accumulator scaling and FSM state type
package fma_fp16_int8_pkg;
  localparam int FP16_BIAS = 15;
  localparam int FP16_MAN = 10;
  localparam int FP16_EXP = 5;
  localparam int FP16_EXP_MAX = (1 << FP16_EXP) - 1;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
  localparam int ACC_LSB_EXP = -25;
  typedef enum logic [1:0] {ACC, DRAIN, NORM, OUT} state_t;
endpackage

// File: rtl/acc_to_fp16.sv
// acc_to_fp16: two's-complement fixed-point sum (LSB 2^-25) to RNE-rounded, saturating FP16
module acc_to_fp16
  import fma_fp16_int8_pkg::*;
#(
  parameter int ACC_W = 58
) (
  input  logic [ACC_W-1:0] acc,
  output logic [15:0]      fp16
);
  localparam int PW = $clog2(ACC_W);
  logic                sign;
  logic                normal;
  logic                guard;
  logic                sticky;
  logic                inc;
  logic [ACC_W-1:0]    mag;
  logic [ACC_W-2:0]    norm;
  logic [PW-1:0]       p;
  logic [7:0]          e;
  logic [FP16_MAN-1:0] frac;
  logic [FP16_MAN+7:0] sum;
  // sign-magnitude, leading-one search, round to nearest even, clamp to max finite
  always_comb begin
    sign = acc[ACC_W-1];
    mag = sign ? -acc : acc;
    p = '0;
    for (int i = 0; i < ACC_W; i++) if (mag[i]) p = PW'(i);
    norm = (ACC_W-1)'(mag << (PW'(ACC_W - 1) - p));
    normal = p >= PW'(FP16_MAN + 1);
    e = normal ? 8'(int'(p) + ACC_LSB_EXP + FP16_BIAS) : 8'd0;
    frac = normal ? norm[ACC_W-2 -: FP16_MAN] : mag[FP16_MAN:1];
    guard = normal ? norm[ACC_W-2-FP16_MAN] : mag[0];
    sticky = normal & (|norm[ACC_W-3-FP16_MAN:0]);
    inc = guard & (sticky | frac[0]);
    sum = {e, frac} + {{(FP16_MAN + 7){1'b0}}, inc};
    fp16 = (sum[FP16_MAN+7:FP16_MAN] >= 8'(FP16_EXP_MAX)) ? {sign, FP16_MAX_FINITE[14:0]} : {sign, sum[14:0]};
  end
endmodule

// File: rtl/fp16_int8_accumulator.sv
// fp16_int8_accumulator: aligns INT8xFP16 products into a wide fixed-point sum, emits one FP16 per vector
module fp16_int8_accumulator
  import fma_fp16_int8_pkg::*;
#(
  parameter int ACC_W = 58,
  parameter int EXP_W = 5,
  parameter int MAN_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_man,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16
);
  state_t           state;
  state_t           next_state;
  logic             take;
  logic             give;
  logic             s1_valid;
  logic [EXP_W-1:0] shift;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W-1:0] s1_aligned;
  logic [ACC_W-1:0] acc;
  logic [15:0]      result;
  // exponent range -15..+16 wraps cleanly onto shift 0..31 in EXP_W bits
  assign shift = in_exp + EXP_W'(FP16_BIAS);
  assign shifted = ACC_W'(in_man) << shift;
  assign take = in_valid & in_ready;
  assign give = out_valid & out_ready;
  acc_to_fp16 #(.ACC_W(ACC_W)) u_conv (.acc(acc), .fp16(result));
  // next state and handshake outputs; drain waits for the align stage to empty into acc
  always_comb begin
    next_state = state;
    in_ready = state == ACC;
    out_valid = state == OUT;
    case (state)
      ACC:   next_state = (take && in_last) ? DRAIN : ACC;
      DRAIN: next_state = s1_valid ? DRAIN : NORM;
      NORM:  next_state = OUT;
      OUT:   next_state = give ? ACC : OUT;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= next_state;
  // align stage: shift product onto the 2^-25 grid and apply sign
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_aligned <= '0;
    end else begin
      s1_valid <= take;
      if (take) s1_aligned <= in_sign ? -shifted : shifted;
    end
  // add stage; cleared when the result is handed off
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (give) acc <= '0;
    else if (s1_valid) acc <= acc + s1_aligned;
  // result register captured during NORM, held through OUT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_fp16 <= 16'h0000;
    else if (state == NORM) out_fp16 <= result;
endmodule

// File: tb/tb_fp16_int8_accumulator.sv
// tb_fp16_int8_accumulator: vector table, corner sequences and random vectors vs a value-level model
module tb_fp16_int8_accumulator;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        in_sign = 0;
  logic [4:0]  in_exp = '0;
  logic [18:0] in_man = '0;
  logic        in_last = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_fp16;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0]        s;
    logic [3:0][5:0]   e;
    logic [3:0][18:0]  m;
    logic [15:0]       x;
  } vec_t;

  vec_t tbl[14];

  fp16_int8_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp16(out_fp16)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic vec_t mk(int n, logic [3:0] s, int e0, int m0, int e1, int m1,
                              int e2, int m2, int e3, int m3, logic [15:0] x);
    vec_t v;
    v.n = 3'(n); v.s = s; v.x = x;
    v.e[0] = 6'(e0); v.e[1] = 6'(e1); v.e[2] = 6'(e2); v.e[3] = 6'(e3);
    v.m[0] = 19'(m0); v.m[1] = 19'(m1); v.m[2] = 19'(m2); v.m[3] = 19'(m3);
    return v;
  endfunction

  // exact value in units of 2^-25, rounded to the FP16 grid by value, then encoded
  function automatic logic [15:0] ref_fp16(longint sum);
    longint mag, ulp, q, r, v;
    int e;
    bit s;
    s = sum < 0;
    mag = s ? -sum : sum;
    if (mag == 0) return 16'h0000;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    ulp = (mag < 2048) ? 2 : (longint'(1) << (e - 10));
    q = mag / ulp;
    r = mag % ulp;
    if (2 * r > ulp || (2 * r == ulp && q[0])) q++;
    v = q * ulp;
    if (v > (longint'(65504) << 25)) return {s, 15'h7BFF};
    if (v < 2048) return {s, 15'(v >> 1)};
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {s, 5'(e - 10), 10'((v >> (e - 10)) - 1024)};
  endfunction

  function automatic longint term(bit s, int e, int m);
    longint t;
    t = longint'(m) << (e + 15);
    return s ? -t : t;
  endfunction

  // call at a negedge; returns at the negedge after the transfer
  task automatic send(bit s, int e, int m, bit last);
    int t = 0;
    in_valid = 1; in_sign = s; in_exp = 5'(e); in_man = 19'(m); in_last = last;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic recv(string name, logic [15:0] want, int hold);
    int t = 0;
    logic [15:0] held;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    held = out_fp16;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold"}, {15'd0, out_valid, out_fp16}, {15'd0, 1'b1, held});
      check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
    end
    check(name, 32'(out_fp16), 32'(want));
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    tbl[0]  = mk(1, 4'b0000, 0, 'h400, 0, 0, 0, 0, 0, 0, 16'h3C00);
    tbl[1]  = mk(3, 4'b0010, 0, 'h800, 0, 'h400, -1, 'hC00, 0, 0, 16'h4100);
    tbl[2]  = mk(2, 4'b0000, 0, 'h400, -11, 'h400, 0, 0, 0, 0, 16'h3C00);
    tbl[3]  = mk(2, 4'b0000, 0, 'h400, -11, 'hC00, 0, 0, 0, 0, 16'h3C02);
    tbl[4]  = mk(2, 4'b0010, 0, 'h400, 0, 'h400, 0, 0, 0, 0, 16'h0000);
    tbl[5]  = mk(4, 4'b0000, 15, 259969, 15, 259969, 15, 259969, 15, 259969, 16'h7BFF);
    tbl[6]  = mk(4, 4'b1111, 15, 259969, 15, 259969, 15, 259969, 15, 259969, 16'hFBFF);
    tbl[7]  = mk(1, 4'b0000, -15, 3, 0, 0, 0, 0, 0, 0, 16'h0002);
    tbl[8]  = mk(1, 4'b0000, -15, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[9]  = mk(1, 4'b0001, 0, 'h400, 0, 0, 0, 0, 0, 0, 16'hBC00);
    tbl[10] = mk(1, 4'b0000, 15, 2047, 0, 0, 0, 0, 0, 0, 16'h7BFF);
    tbl[11] = mk(1, 4'b0000, 14, 4095, 0, 0, 0, 0, 0, 0, 16'h7BFF);
    tbl[12] = mk(1, 4'b0000, 16, 1, 0, 0, 0, 0, 0, 0, 16'h5400);
    tbl[13] = mk(1, 4'b0000, -15, 2047, 0, 0, 0, 0, 0, 0, 16'h0400);

    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_fp16", 32'(out_fp16), 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // latency: out_valid rises exactly three edges after the last beat
    in_valid = 1; in_sign = 0; in_exp = 5'd0; in_man = 19'h400; in_last = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_last = 0;
    check("lat_in_ready_drain", 32'(in_ready), 32'd0);
    check("lat_valid_k0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k3", 32'(out_valid), 32'd1);
    recv("lat_result", 16'h3C00, 0);

    for (int i = 0; i < 14; i++) begin
      for (int b = 0; b < int'(tbl[i].n); b++)
        send(tbl[i].s[b], int'($signed(tbl[i].e[b])), int'(tbl[i].m[b]), b == int'(tbl[i].n) - 1);
      recv($sformatf("vec%0d", i), tbl[i].x, 0);
    end

    // backpressure, then the following vector must start from zero
    send(0, 0, 'h400, 0);
    send(0, 0, 'h400, 1);
    recv("bp_result", 16'h4000, 5);
    send(0, 0, 'h400, 1);
    recv("bp_cleared", 16'h3C00, 0);

    // reset mid-vector discards partial sum
    send(0, 0, 'h400, 0);
    send(0, 0, 'h800, 0);
    rst_n = 0;
    #1;
    check("rst_mid_vec_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_mid_vec_in_ready", 32'(in_ready), 32'd1);
    send(0, 0, 'h400, 1);
    recv("rst_mid_vec_next", 16'h3C00, 0);

    // reset while the result is pending drops it
    send(1, 0, 'h400, 1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      check("rst_mid_out_pending", 32'(out_valid), 32'd1);
    end
    rst_n = 0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_fp16", 32'(out_fp16), 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(0, 0, 'h800, 1);
    recv("rst_mid_out_next", 16'h4000, 0);

    // random vectors against the value-level model
    for (int v = 0; v < 40; v++) begin
      int n;
      longint sum;
      n = int'($urandom_range(1, 4));
      sum = 0;
      for (int b = 0; b < n; b++) begin
        bit s;
        int e, m;
        s = 1'($urandom_range(0, 1));
        e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 16)) : int'($urandom_range(0, 26)) - 15;
        m = int'($urandom_range(0, 128)) * int'($urandom_range(0, 2047));
        sum += term(s, e, m);
        send(s, e, m, b == n - 1);
      end
      recv($sformatf("rand%0d", v), ref_fp16(sum), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
